ran_key_assembler: RTL and testbench

RAN_KEY_ASSEMBLER -- requirements
Module: ran_key_assembler

---
 rtl/ran_pkg.sv | 12 +
 rtl/ran_sync_edge.sv | 24 ++
 rtl/ran_key_assembler.sv | 122 ++++++++++++
 tb/tb_ran_key_assembler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ran_pkg.sv
// Shared types and defaults for the RAN key assembler.
package ran_pkg;
  localparam int KEY_W_DEF      = 16;
  localparam int RCT_CUTOFF_DEF = 12;
  localparam int SYNC_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;
endpackage

// File: rtl/ran_sync_edge.sv
// Synchronizes an asynchronous level into clk and emits a one-cycle pulse on its rising edge.
module ran_sync_edge
  import ran_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);
  logic [SYNC_DEPTH-1:0] sync;
  logic                  hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], async_in};
      hist <= sync[SYNC_DEPTH-1];
    end
  end

  assign rise = sync[SYNC_DEPTH-1] & ~hist;
endmodule

// File: rtl/ran_key_assembler.sv
// Assembles KEY_W whitened random bits into a key on a push-button request.
// Define RAN_HEALTH_EN to compile in the repetition-count health test.
module ran_key_assembler
  import ran_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic             bit_in,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
  output logic             health_fail
);
  localparam int CNT_W = $clog2(KEY_W + 1);

  state_t           state, state_nxt;
  logic             req;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] shreg, key_q;
  logic             last_cap;
  logic             rct_trip;

  ran_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sample),
    .rise     (req)
  );

  assign last_cap = (cnt == CNT_W'(KEY_W - 1));

`ifdef RAN_HEALTH_EN
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

  logic [RUN_W-1:0] run, run_nxt;
  logic             prev_bit, hf;

  // Run length restarts at 1 on the first capture and on every bit change.
  always_comb begin
    run_nxt = RUN_W'(1);
    if (cnt != '0 && bit_in == prev_bit)
      run_nxt = (run == RUN_W'(RCT_CUTOFF)) ? run : run + RUN_W'(1);
  end

  assign rct_trip = (state == COLLECT) && (run_nxt == RUN_W'(RCT_CUTOFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= '0;
      prev_bit <= 1'b0;
      hf       <= 1'b0;
    end else if (state == IDLE && req) begin
      run <= '0;
      hf  <= 1'b0;
    end else if (state == COLLECT) begin
      run      <= run_nxt;
      prev_bit <= bit_in;
      if (rct_trip) hf <= 1'b1;
    end
  end

  assign health_fail = hf;
`else
  assign rct_trip    = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = COLLECT;
      COLLECT: begin
        if (rct_trip)      state_nxt = IDLE;
        else if (last_cap) state_nxt = HOLD;
      end
      HOLD:    if (key_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // key_q is only loaded on a complete key, so an aborted collection leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
      key_q <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cnt   <= '0;
          shreg <= '0;
        end
        COLLECT: begin
          shreg <= {shreg[KEY_W-2:0], bit_in};
          if (!rct_trip) begin
            if (last_cap) begin
              key_q <= {shreg[KEY_W-2:0], bit_in};
              cnt   <= CNT_W'(KEY_W);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign key_valid = (state == HOLD);
  assign busy      = (state == COLLECT);
  assign key_out   = key_q;
endmodule

// File: tb/tb_ran_key_assembler.sv
// Directed bench for ran_key_assembler; expected keys queue up at request time and are checked at handshake.
module tb_ran_key_assembler;
  logic        clk, rst_n, sample, bit_in, key_ready;
  logic        key_valid, busy, health_fail;
  logic [15:0] key_out;

  int n_chk = 0, n_pass = 0, n_fail = 0, n_hs = 0, hs0;
  logic [15:0] exp_q[$];

  ran_key_assembler #(.KEY_W(16), .RCT_CUTOFF(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (sample),
    .bit_in      (bit_in),
    .key_ready   (key_ready),
    .key_valid   (key_valid),
    .key_out     (key_out),
    .busy        (busy),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edge 1 samples sample high, edge 3 enters COLLECT, captures start at edge 4.
  task automatic collect(input logic [15:0] pat, input int ncap, input bit hold, input int repulse);
    sample = 1'b1;
    step(1);
    if (!hold) sample = 1'b0;
    step(2);
    chk("busy_on", busy, 1);
    for (int i = 0; i < ncap; i++) begin
      if (i == 15) chk("valid_early", key_valid, 0);
      if (i == repulse)     sample = 1'b1;
      if (i == repulse + 1) sample = 1'b0;
      bit_in = pat[15-i];
      step(1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      n_hs++;
      chk("hs_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("hs_key", key_out, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; sample = 1'b0; bit_in = 1'b0; key_ready = 1'b0;
    step(2);
    chk("rst_valid", key_valid, 0);
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_health", health_fail, 0);
    rst_n = 1'b1;
    step(2);

    // Basic alternating key, ready already high outside HOLD
    key_ready = 1'b1;
    exp_q.push_back(16'hAAAA);
    collect(16'hAAAA, 16, 0, -1);
    chk("t1_valid", key_valid, 1);
    chk("t1_key", key_out, 16'hAAAA);
    chk("t1_health", health_fail, 0);
    chk("t1_busy", busy, 0);
    step(1);
    chk("t1_valid_1cyc", key_valid, 0);
    chk("t1_key_kept", key_out, 16'hAAAA);

    // Backpressure holds the key stable
    key_ready = 1'b0;
    exp_q.push_back(16'hAAAA);
    collect(16'hAAAA, 16, 0, -1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold", {key_valid, key_out}, {1'b1, 16'hAAAA});
      step(1);
    end
    key_ready = 1'b1;
    step(1);
    chk("t2_release", key_valid, 0);
    chk("t2_idle", busy, 0);

    // Constant-one stream
`ifdef RAN_HEALTH_EN
    collect(16'hFFFF, 12, 0, -1);
    chk("t3_health", health_fail, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", key_valid, 0);
    chk("t3_key_kept", key_out, 16'hAAAA);
    step(3);
    chk("t3_sticky", health_fail, 1);
    chk("t3_no_valid", key_valid, 0);
    exp_q.push_back(16'hC3A5);
    collect(16'hC3A5, 16, 0, -1);
    chk("t3_cleared", health_fail, 0);
    chk("t3_valid2", key_valid, 1);
    chk("t3_key2", key_out, 16'hC3A5);
    step(1);
`else
    exp_q.push_back(16'hFFFF);
    collect(16'hFFFF, 16, 0, -1);
    chk("t3_valid", key_valid, 1);
    chk("t3_key", key_out, 16'hFFFF);
    chk("t3_health", health_fail, 0);
    step(1);
`endif

    // Reset after 8 captures aborts the key
    collect(16'h9E37, 8, 0, -1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", key_valid, 0);
    chk("t4_rst_key", key_out, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_health", health_fail, 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("t4_idle", {busy, key_valid}, 0);
    exp_q.push_back(16'h9E37);
    collect(16'h9E37, 16, 0, -1);
    chk("t4_valid", key_valid, 1);
    chk("t4_key", key_out, 16'h9E37);
    step(1);

    // Sample held high through reset release and for 100 cycles
    hs0 = n_hs;
    rst_n = 1'b0;
    sample = 1'b1;
    step(1);
    rst_n = 1'b1;
    exp_q.push_back(16'h6B2D);
    collect(16'h6B2D, 16, 1, -1);
    chk("t5_valid", key_valid, 1);
    step(81);
    sample = 1'b0;
    step(5);
    chk("t5_one_key", n_hs - hs0, 1);

    // Second pulse during COLLECT is dropped
    hs0 = n_hs;
    exp_q.push_back(16'h4D71);
    collect(16'h4D71, 16, 0, 5);
    chk("t6_valid", key_valid, 1);
    step(30);
    chk("t6_one_key", n_hs - hs0, 1);
    chk("t6_idle", busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
